// File: rtl/tmnt_video_pkg.sv
// Shared definitions for the palette colour bus: region tags, control-register
// bit positions, and special pixel codes.
package tmnt_video_pkg;

  typedef enum logic [1:0] {
    REG_FIX = 2'b00,
    REG_LA  = 2'b01,
    REG_LB  = 2'b10,
    REG_OBJ = 2'b11
  } region_e;

  localparam int unsigned CTRL_AB_SWAP = 0;
  localparam int unsigned CTRL_SHD_EN  = 1;
  localparam int unsigned CTRL_OBJ_TOP = 2;
  localparam int unsigned CTRL_W       = 3;

  localparam logic [3:0] PIX_TRANSP = 4'h0;
  localparam logic [3:0] PIX_SHADOW = 4'hF;

  typedef struct packed {
    logic [3:0] pal;
    logic [3:0] pix;
  } px_t;

  function automatic logic is_opaque(input px_t p, input logic en);
    return en && (p.pix != PIX_TRANSP);
  endfunction

endpackage

// File: rtl/tmnt_prio_sel.sv
// Stage-2 resolver: picks the winning layer, applies sprite shadow and blanking.
// Purely combinational; the parent registers the result.
module tmnt_prio_sel
  import tmnt_video_pkg::*;
(
  input  px_t               fix,
  input  px_t               la,
  input  px_t               lb,
  input  px_t               obj,
  input  logic              obj_pri,
  input  logic [3:0]        op,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [9:0]        bg,
  input  logic              blank,
  output logic [9:0]        cd,
  output logic              shadow
);

  logic    fix_op, la_op, lb_op, obj_op;
  logic    front_op, back_op;
  px_t     front_px, back_px;
  region_e front_rg, back_rg;
  logic    obj_above, obj_wins, obj_shd;

  assign {obj_op, lb_op, la_op, fix_op} = op;

  always_comb begin
    front_px = ctrl[CTRL_AB_SWAP] ? lb : la;
    back_px  = ctrl[CTRL_AB_SWAP] ? la : lb;
    front_rg = ctrl[CTRL_AB_SWAP] ? REG_LB : REG_LA;
    back_rg  = ctrl[CTRL_AB_SWAP] ? REG_LA : REG_LB;
    front_op = ctrl[CTRL_AB_SWAP] ? lb_op : la_op;
    back_op  = ctrl[CTRL_AB_SWAP] ? la_op : lb_op;

    // A low-priority sprite still wins when the front layer is see-through,
    // so the whole priority ladder collapses to one "does OBJ win" test.
    obj_above = !obj_pri || ctrl[CTRL_OBJ_TOP];
    obj_wins  = !fix_op && obj_op && (obj_above || !front_op);
    obj_shd   = obj_wins && ctrl[CTRL_SHD_EN] && (obj.pix == PIX_SHADOW);

    cd     = bg;
    shadow = 1'b0;
    if (!blank) begin
      shadow = obj_shd;
      if (fix_op)
        cd = {REG_FIX, fix};
      else if (obj_wins && !obj_shd)
        cd = {REG_OBJ, obj};
      else if (front_op)
        cd = {front_rg, front_px};
      else if (back_op)
        cd = {back_rg, back_px};
    end
  end

endmodule

// File: rtl/tmnt_color_mixer.sv
// Palette colour bus transmitter: two ce_pix-advanced stages merging FIX, layer A,
// layer B and sprite pixels into CD/SHADOW/NCBLK, all driven from registers.
module tmnt_color_mixer
  import tmnt_video_pkg::*;
#(
  parameter int unsigned PIPE_DLY = 2,
  parameter logic [9:0]  BG_RESET = 10'h000
) (
  input  logic        clk_sys,
  input  logic        NRESET,
  input  logic        ce_pix,
  input  logic [7:0]  FIX_PX,
  input  logic [7:0]  LA_PX,
  input  logic [7:0]  LB_PX,
  input  logic [8:0]  OBJ_PX,
  input  logic        HBLK,
  input  logic        VBLK,
  input  logic [3:0]  LAYER_EN,
  input  logic        REG_WR,
  input  logic        REG_SEL,
  input  logic [9:0]  REG_DIN,
  output logic [9:0]  CD,
  output logic        SHADOW,
  output logic        NCBLK
);

  if (PIPE_DLY != 2) begin : g_bad_pipe_dly
    $error("tmnt_color_mixer: PIPE_DLY must be 2");
  end

  logic [CTRL_W-1:0] ctrl_q, ctrl_nx;
  logic [9:0]        bg_q, bg_nx;

  px_t               s1_fix, s1_la, s1_lb, s1_obj;
  logic              s1_pri;
  logic [3:0]        s1_op;
  logic              s1_hblk, s1_vblk;
  logic [CTRL_W-1:0] s1_ctrl;
  logic [9:0]        s1_bg;

  logic [9:0]        mix_cd;
  logic              mix_shd;

  // Write-through so a write coinciding with ce_pix reaches that same sample.
  always_comb begin
    ctrl_nx = ctrl_q;
    bg_nx   = bg_q;
    if (REG_WR && !REG_SEL) ctrl_nx = REG_DIN[CTRL_W-1:0];
    if (REG_WR &&  REG_SEL) bg_nx   = REG_DIN;
  end

  always_ff @(posedge clk_sys) begin
    if (!NRESET) begin
      ctrl_q  <= '0;
      bg_q    <= BG_RESET;
      s1_fix  <= '0;
      s1_la   <= '0;
      s1_lb   <= '0;
      s1_obj  <= '0;
      s1_pri  <= 1'b0;
      s1_op   <= '0;
      s1_hblk <= 1'b0;
      s1_vblk <= 1'b0;
      s1_ctrl <= '0;
      s1_bg   <= BG_RESET;
      CD      <= BG_RESET;
      SHADOW  <= 1'b0;
      NCBLK   <= 1'b0;
    end else begin
      ctrl_q <= ctrl_nx;
      bg_q   <= bg_nx;
      if (ce_pix) begin
        s1_fix  <= FIX_PX;
        s1_la   <= LA_PX;
        s1_lb   <= LB_PX;
        s1_obj  <= OBJ_PX[7:0];
        s1_pri  <= OBJ_PX[8];
        s1_op   <= {is_opaque(OBJ_PX[7:0], LAYER_EN[3]),
                    is_opaque(LB_PX,       LAYER_EN[2]),
                    is_opaque(LA_PX,       LAYER_EN[1]),
                    is_opaque(FIX_PX,      LAYER_EN[0])};
        s1_hblk <= HBLK;
        s1_vblk <= VBLK;
        s1_ctrl <= ctrl_nx;
        s1_bg   <= bg_nx;
        CD      <= mix_cd;
        SHADOW  <= mix_shd;
        NCBLK   <= ~(s1_hblk | s1_vblk);
      end
    end
  end

  tmnt_prio_sel u_prio_sel (
    .fix     (s1_fix),
    .la      (s1_la),
    .lb      (s1_lb),
    .obj     (s1_obj),
    .obj_pri (s1_pri),
    .op      (s1_op),
    .ctrl    (s1_ctrl),
    .bg      (s1_bg),
    .blank   (s1_hblk | s1_vblk),
    .cd      (mix_cd),
    .shadow  (mix_shd)
  );

endmodule

// File: tb/tb_tmnt_color_mixer.sv
// Self-checking bench for tmnt_color_mixer: spec vector table, hand-written
// latency/blank/write-timing sequences, and randomized traffic against a model.
module tb_tmnt_color_mixer;

  logic       clk_sys = 1'b0;
  logic       NRESET  = 1'b0;
  logic       ce_pix  = 1'b0;
  logic [7:0] FIX_PX  = '0;
  logic [7:0] LA_PX   = '0;
  logic [7:0] LB_PX   = '0;
  logic [8:0] OBJ_PX  = '0;
  logic       HBLK    = 1'b0;
  logic       VBLK    = 1'b0;
  logic [3:0] LAYER_EN = 4'hF;
  logic       REG_WR  = 1'b0;
  logic       REG_SEL = 1'b0;
  logic [9:0] REG_DIN = '0;
  logic [9:0] CD;
  logic       SHADOW;
  logic       NCBLK;

  tmnt_color_mixer #(.PIPE_DLY(2), .BG_RESET(10'h000)) dut (
    .clk_sys  (clk_sys),
    .NRESET   (NRESET),
    .ce_pix   (ce_pix),
    .FIX_PX   (FIX_PX),
    .LA_PX    (LA_PX),
    .LB_PX    (LB_PX),
    .OBJ_PX   (OBJ_PX),
    .HBLK     (HBLK),
    .VBLK     (VBLK),
    .LAYER_EN (LAYER_EN),
    .REG_WR   (REG_WR),
    .REG_SEL  (REG_SEL),
    .REG_DIN  (REG_DIN),
    .CD       (CD),
    .SHADOW   (SHADOW),
    .NCBLK    (NCBLK)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [9:0] cd;
    logic       sh;
    logic       nc;
  } out_t;

  typedef struct {
    string      nm;
    logic [7:0] fix, la, lb;
    logic [8:0] obj;
    logic       h, v;
    logic [3:0] len;
    logic [2:0] ctrl;
    logic [9:0] e_cd;
    logic       e_sh, e_nc;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;

  logic [2:0] m_ctrl;
  logic [9:0] m_bg;
  out_t       m_pend, m_out;

  vec_t tbl[13];
  logic hp[9]    = '{0, 0, 1, 1, 1, 1, 0, 0, 0};
  logic hp_nc[9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};

  // Slots in descending priority: fix, obj(high), front, obj(low), back.
  function automatic out_t ref_mix(input logic [7:0] fix, la, lb, input logic [8:0] obj,
                                   input logic h, v, input logic [3:0] len,
                                   input logic [2:0] ctrl, input logic [9:0] bg);
    logic [9:0] col[5];
    bit         op[5];
    int         os;
    out_t       r;
    r.cd = bg;
    r.sh = 1'b0;
    r.nc = !(h | v);
    if (!r.nc) return r;
    os = (obj[8] && !ctrl[2]) ? 3 : 1;
    col[0] = {2'b00, fix};          op[0] = (fix[3:0] != 0) && len[0];
    col[4 - os] = '0;               op[4 - os] = 0;
    col[os] = {2'b11, obj[7:0]};    op[os] = (obj[3:0] != 0) && len[3];
    if (ctrl[0]) begin
      col[2] = {2'b10, lb}; op[2] = (lb[3:0] != 0) && len[2];
      col[4] = {2'b01, la}; op[4] = (la[3:0] != 0) && len[1];
    end else begin
      col[2] = {2'b01, la}; op[2] = (la[3:0] != 0) && len[1];
      col[4] = {2'b10, lb}; op[4] = (lb[3:0] != 0) && len[2];
    end
    for (int s = 0; s < 5; s++) begin
      if (op[s]) begin
        if (s == os && ctrl[1] && obj[3:0] == 4'hF) begin
          r.sh = 1'b1;
          continue;
        end
        r.cd = col[s];
        return r;
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [9:0] e_cd, input logic e_sh, input logic e_nc);
    n_cmp++;
    if (CD !== e_cd || SHADOW !== e_sh || NCBLK !== e_nc) begin
      n_bad++;
      $display("FAIL %s: got CD=%h SHADOW=%b NCBLK=%b, need CD=%h SHADOW=%b NCBLK=%b",
               nm, CD, SHADOW, NCBLK, e_cd, e_sh, e_nc);
    end
  endtask

  task automatic drive(input logic [7:0] f, a, b, input logic [8:0] o,
                       input logic h, v, input logic [3:0] len);
    FIX_PX = f; LA_PX = a; LB_PX = b; OBJ_PX = o;
    HBLK = h; VBLK = v; LAYER_EN = len;
  endtask

  task automatic pulse();
    ce_pix = 1'b1;
    @(posedge clk_sys);
    #1;
    ce_pix = 1'b0;
    m_out  = m_pend;
    m_pend = ref_mix(FIX_PX, LA_PX, LB_PX, OBJ_PX, HBLK, VBLK, LAYER_EN, m_ctrl, m_bg);
  endtask

  task automatic reg_write(input logic sel, input logic [9:0] din);
    REG_WR = 1'b1; REG_SEL = sel; REG_DIN = din;
    @(posedge clk_sys);
    #1;
    REG_WR = 1'b0;
    if (sel) m_bg = din;
    else     m_ctrl = din[2:0];
  endtask

  task automatic model_reset();
    m_ctrl = '0;
    m_bg   = 10'h000;
    m_out  = '{cd: 10'h000, sh: 1'b0, nc: 1'b0};
    m_pend = '{cd: 10'h000, sh: 1'b0, nc: 1'b1};
  endtask

  function automatic logic [7:0] rpx();
    logic [3:0] pix;
    if ($urandom_range(0, 2) == 0)      pix = 4'h0;
    else if ($urandom_range(0, 3) == 0) pix = 4'hF;
    else                                pix = 4'($urandom);
    return {4'($urandom), pix};
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{"all_transp_bg", 8'h00, 8'h00, 8'h00, 9'h000, 0, 0, 4'hF, 3'd0, 10'h155, 0, 1};
    tbl[1]  = '{"a_above_b",     8'h00, 8'h53, 8'h72, 9'h000, 0, 0, 4'hF, 3'd0, 10'h153, 0, 1};
    tbl[2]  = '{"b_above_a",     8'h00, 8'h53, 8'h72, 9'h000, 0, 0, 4'hF, 3'd1, 10'h272, 0, 1};
    tbl[3]  = '{"obj_behind_a",  8'h00, 8'h31, 8'h00, 9'h1A4, 0, 0, 4'hF, 3'd0, 10'h131, 0, 1};
    tbl[4]  = '{"obj_top",       8'h00, 8'h31, 8'h00, 9'h1A4, 0, 0, 4'hF, 3'd4, 10'h3A4, 0, 1};
    tbl[5]  = '{"shadow_on",     8'h00, 8'h00, 8'h46, 9'h02F, 0, 0, 4'hF, 3'd2, 10'h246, 1, 1};
    tbl[6]  = '{"shadow_off",    8'h00, 8'h00, 8'h46, 9'h02F, 0, 0, 4'hF, 3'd0, 10'h32F, 0, 1};
    tbl[7]  = '{"fix_over_shd",  8'h9C, 8'h00, 8'h00, 9'h02F, 0, 0, 4'hF, 3'd2, 10'h09C, 0, 1};
    tbl[8]  = '{"fix_masked",    8'h9C, 8'h31, 8'h00, 9'h000, 0, 0, 4'hE, 3'd0, 10'h131, 0, 1};
    tbl[9]  = '{"vblank",        8'h00, 8'h31, 8'h00, 9'h000, 0, 1, 4'hF, 3'd0, 10'h155, 0, 0};
    tbl[10] = '{"shadow_on_bg",  8'h00, 8'h00, 8'h00, 9'h0AF, 0, 0, 4'hF, 3'd2, 10'h155, 1, 1};
    tbl[11] = '{"shadow_lo_pri", 8'h00, 8'h00, 8'h46, 9'h12F, 0, 0, 4'hF, 3'd2, 10'h246, 1, 1};
    tbl[12] = '{"lo_pri_hidden", 8'h00, 8'h31, 8'h46, 9'h12F, 0, 0, 4'hF, 3'd2, 10'h131, 0, 1};

    // Reset held for 3 clocks, with a pixel enable arriving while still in reset.
    model_reset();
    drive(8'h9C, 8'h31, 8'h46, 9'h02F, 0, 0, 4'hF);
    repeat (3) @(posedge clk_sys);
    #1;
    pulse();
    chk("reset", 10'h000, 1'b0, 1'b0);
    NRESET = 1'b1;
    model_reset();

    for (int i = 0; i < 13; i++) begin
      reg_write(1'b1, 10'h155);
      reg_write(1'b0, {7'b0, tbl[i].ctrl});
      drive(tbl[i].fix, tbl[i].la, tbl[i].lb, tbl[i].obj, tbl[i].h, tbl[i].v, tbl[i].len);
      pulse();
      pulse();
      chk(tbl[i].nm, tbl[i].e_cd, tbl[i].e_sh, tbl[i].e_nc);
    end

    // Two-enable latency, then hold while ce_pix stays low.
    reg_write(1'b0, 10'h000);
    drive(8'h00, 8'h31, 8'h00, 9'h000, 0, 0, 4'hF);
    pulse();
    pulse();
    drive(8'h00, 8'h00, 8'h00, 9'h000, 0, 0, 4'hF);
    pulse();
    chk("latency_1ce", 10'h131, 1'b0, 1'b1);
    pulse();
    chk("latency_2ce", 10'h155, 1'b0, 1'b1);
    drive(8'h00, 8'h53, 8'h72, 9'h000, 1, 0, 4'hF);
    repeat (3) @(posedge clk_sys);
    #1;
    chk("ce_low_hold", 10'h155, 1'b0, 1'b1);

    // Control write on the same clk_sys as ce_pix is seen by that sample.
    drive(8'h00, 8'h53, 8'h72, 9'h000, 0, 0, 4'hF);
    pulse();
    REG_WR = 1'b1; REG_SEL = 1'b0; REG_DIN = 10'h001;
    m_ctrl = 3'd1;
    pulse();
    REG_WR = 1'b0;
    reg_write(1'b0, 10'h000);
    pulse();
    chk("wr_same_ce", 10'h272, 1'b0, 1'b1);
    pulse();
    chk("wr_reverted", 10'h153, 1'b0, 1'b1);

    // Four-pixel HBLK pulse.
    drive(8'h00, 8'h31, 8'h00, 9'h000, 0, 0, 4'hF);
    pulse();
    pulse();
    for (int k = 0; k < 9; k++) begin
      HBLK = hp[k];
      pulse();
      chk($sformatf("hblk_px%0d", k), hp_nc[k] ? 10'h131 : 10'h155, 1'b0, hp_nc[k]);
    end
    HBLK = 1'b0;

    // Randomized traffic against the reference model, with a mid-line reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        reg_write(1'($urandom_range(0, 1)), 10'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk_sys);
        #1;
        chk("rand_hold", m_out.cd, m_out.sh, m_out.nc);
      end
      if (i == 200) begin
        NRESET = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("midline_reset", 10'h000, 1'b0, 1'b0);
        NRESET = 1'b1;
        model_reset();
      end
      drive(rpx(), rpx(), rpx(), {1'($urandom), rpx()},
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0),
            ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF);
      pulse();
      chk("rand_px", m_out.cd, m_out.sh, m_out.nc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
